// File: rtl/sm4_seq_ctrl.sv
// Sequencer between UART receive buffers and the SM4 core: key load, frame slicing,
// per-block encryption and ciphertext hand-off. Optional watchdog: SM4_TIMEOUT_EN.
`timescale 1ns/1ps

// state      | meaning
// IDLE       | waiting for start, key/group count latched on start
// KEY_LOAD   | request key expansion
// KEY_WAIT   | waiting for sm4_key_ready
// WAIT_FRAME | waiting for frame_valid, latch frame and blocks-per-frame
// BLK_GO     | present block blk_idx to the core
// BLK_WAIT   | waiting for sm4_done
// BLK_OUT    | ciphertext offered to transmitter until accepted
// FRAME_DONE | acknowledge frame to receiver
// ALL_DONE   | session complete, waiting for start to drop
// ERR        | watchdog expired, left only via abort/reset (SM4_TIMEOUT_EN)
module sm4_seq_ctrl #(
   parameter int BLK_W   = 128,
   parameter int MAX_BLK = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     start,
   input  logic                     abort,
   input  logic [BLK_W-1:0]         key_in,
   input  logic [31:0]              group_total,
   input  logic [2:0]               battery_level,
   input  logic [BLK_W*MAX_BLK-1:0] frame_in,
   input  logic                     frame_valid,
   output logic                     frame_ack,
   output logic [BLK_W-1:0]         sm4_key,
   output logic                     sm4_key_load,
   input  logic                     sm4_key_ready,
   output logic [BLK_W-1:0]         sm4_din,
   output logic                     sm4_go,
   input  logic                     sm4_done,
   input  logic [BLK_W-1:0]         sm4_dout,
   output logic [BLK_W-1:0]         tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [31:0]              group_cnt,
   output logic                     busy,
   output logic                     all_done,
   output logic                     err
);

   localparam int CNT_W = $clog2(MAX_BLK + 1);

   typedef enum logic [3:0] {
      IDLE, KEY_LOAD, KEY_WAIT, WAIT_FRAME, BLK_GO, BLK_WAIT, BLK_OUT, FRAME_DONE,
`ifdef SM4_TIMEOUT_EN
      ERR,
`endif
      ALL_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      gtotal_q;
   logic [BLK_W-1:0] frame_q [MAX_BLK];
   logic [CNT_W-1:0] bpf_q, blk_idx;
   logic             tx_accept, last_grp, last_blk;

   assign tx_accept = (state == BLK_OUT) && tx_valid && tx_ready;
   assign last_grp  = (group_cnt + 32'd1) == gtotal_q;
   assign last_blk  = (blk_idx + CNT_W'(1)) == bpf_q;
   assign busy      = (state != IDLE) && (state != ALL_DONE);

`ifdef SM4_TIMEOUT_EN
   logic [31:0] wd_cnt;
   logic        wd_tc;

   assign wd_tc = (wd_cnt == 32'd0);

   // Down-counter reloaded on every state change; terminal count only matters in the waits.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wd_cnt <= '0;
      end else if (state_nxt != state) begin
         wd_cnt <= 32'(TIMEOUT - 1);
      end else if ((state == KEY_WAIT) || (state == BLK_WAIT)) begin
         wd_cnt <= wd_cnt - 32'd1;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) err <= 1'b0;
      else      err <= (state == ERR) && !abort;
   end
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge res) begin
      if (!res) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (start) state_nxt = (group_total == 32'd0) ? ALL_DONE : KEY_LOAD;
         KEY_LOAD:   state_nxt = KEY_WAIT;
         // A ready level left over from a previous expansion is not trusted during the strobe.
         KEY_WAIT: begin
            if (sm4_key_ready && !sm4_key_load) state_nxt = WAIT_FRAME;
`ifdef SM4_TIMEOUT_EN
            else if (wd_tc) state_nxt = ERR;
`endif
         end
         WAIT_FRAME: if (frame_valid) state_nxt = BLK_GO;
         BLK_GO:     state_nxt = BLK_WAIT;
         BLK_WAIT: begin
            if (sm4_done) state_nxt = BLK_OUT;
`ifdef SM4_TIMEOUT_EN
            else if (wd_tc) state_nxt = ERR;
`endif
         end
         BLK_OUT: begin
            if (tx_accept) begin
               if (last_grp)      state_nxt = ALL_DONE;
               else if (last_blk) state_nxt = FRAME_DONE;
               else               state_nxt = BLK_GO;
            end
         end
         FRAME_DONE: state_nxt = WAIT_FRAME;
         ALL_DONE:   if (!start) state_nxt = IDLE;
`ifdef SM4_TIMEOUT_EN
         ERR:        state_nxt = ERR;
`endif
         default:    state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sm4_key      <= '0;
         gtotal_q     <= '0;
         group_cnt    <= '0;
         bpf_q        <= '0;
         blk_idx      <= '0;
         for (int k = 0; k < MAX_BLK; k++) frame_q[k] <= '0;
         sm4_din      <= '0;
         sm4_go       <= 1'b0;
         sm4_key_load <= 1'b0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         frame_ack    <= 1'b0;
         all_done     <= 1'b0;
      end else begin
         sm4_key_load <= (state == KEY_LOAD)   && !abort;
         sm4_go       <= (state == BLK_GO)     && !abort;
         frame_ack    <= (state == FRAME_DONE) && !abort;
         all_done     <= (state == ALL_DONE)   && !abort;
         if (abort) begin
            tx_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     sm4_key   <= key_in;
                     gtotal_q  <= group_total;
                     group_cnt <= '0;
                  end
               end
               WAIT_FRAME: begin
                  if (frame_valid) begin
                     for (int k = 0; k < MAX_BLK; k++) frame_q[k] <= frame_in[k*BLK_W +: BLK_W];
                     case (battery_level)
                        3'd1:    bpf_q <= CNT_W'(3);
                        3'd2:    bpf_q <= CNT_W'(2);
                        default: bpf_q <= CNT_W'(1);
                     endcase
                     blk_idx <= '0;
                  end
               end
               BLK_GO: sm4_din <= frame_q[blk_idx];
               BLK_WAIT: begin
                  if (sm4_done) begin
                     tx_data  <= sm4_dout;
                     tx_valid <= 1'b1;
                  end
               end
               BLK_OUT: begin
                  if (tx_accept) begin
                     tx_valid  <= 1'b0;
                     group_cnt <= group_cnt + 32'd1;
                     if (!last_grp && !last_blk) blk_idx <= blk_idx + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sm4_seq_ctrl.sv
// Directed bench for sm4_seq_ctrl with behavioural key-expansion, SM4 core, receiver and transmitter.
`timescale 1ns/1ps

module tb_sm4_seq_ctrl;

   localparam int BLK_W    = 128;
   localparam int MAX_BLK  = 3;
   localparam int CORE_DLY = 20;
   localparam int LIMIT    = 5000;
   localparam logic [127:0] MASK = {4{32'hDEAD_BEEF}};
   localparam logic [127:0] KEY  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   logic         clk = 1'b0, res = 1'b0, start = 1'b0, abort = 1'b0;
   logic [127:0] key_in = '0;
   logic [31:0]  group_total = '0;
   logic [2:0]   battery_level = '0;
   logic [383:0] frame_in;
   logic         frame_valid = 1'b1;
   logic         frame_ack, sm4_key_load, sm4_go, tx_valid, busy, all_done, err;
   logic [127:0] sm4_key, sm4_din, tx_data;
   logic         sm4_key_ready = 1'b0, sm4_done = 1'b0, tx_ready = 1'b1;
   logic [127:0] sm4_dout = '0;
   logic [31:0]  group_cnt;

   int n_checks = 0, n_fail = 0;

   sm4_seq_ctrl #(.BLK_W(BLK_W), .MAX_BLK(MAX_BLK), .TIMEOUT(16)) dut (
      .clk(clk), .res(res), .start(start), .abort(abort), .key_in(key_in),
      .group_total(group_total), .battery_level(battery_level), .frame_in(frame_in),
      .frame_valid(frame_valid), .frame_ack(frame_ack), .sm4_key(sm4_key),
      .sm4_key_load(sm4_key_load), .sm4_key_ready(sm4_key_ready), .sm4_din(sm4_din),
      .sm4_go(sm4_go), .sm4_done(sm4_done), .sm4_dout(sm4_dout), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .group_cnt(group_cnt), .busy(busy),
      .all_done(all_done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] plain(input int f, input int b);
      plain = {32'hA5A5_0000 + 32'(f * 16 + b), 32'h1234_5678, 32'(f), 32'(b)};
   endfunction

   function automatic logic [127:0] cipher(input logic [127:0] p, input logic [127:0] k);
      cipher = p ^ k ^ MASK;
   endfunction

   // Receiver: refills a new frame a few cycles after each acknowledge.
   int ack_total = 0, frame_base = 0, fv_hold = 0;
   always @(negedge clk) begin
      if (frame_ack === 1'b1) begin
         ack_total++;
         frame_valid = 1'b0;
         fv_hold = 3;
      end else if (fv_hold > 0) begin
         fv_hold--;
         if (fv_hold == 0) frame_valid = 1'b1;
      end
      for (int b = 0; b < MAX_BLK; b++) frame_in[b*BLK_W +: BLK_W] = plain(ack_total - frame_base, b);
   end

   // Key expansion: ready pulse three cycles after the load strobe.
   int kl_total = 0, kr_cnt = 0;
   always @(negedge clk) begin
      sm4_key_ready = 1'b0;
      if (kr_cnt > 0) begin
         kr_cnt--;
         if (kr_cnt == 0) sm4_key_ready = 1'b1;
      end
      if (sm4_key_load === 1'b1) begin
         kl_total++;
         kr_cnt = 3;
      end
   end

   // SM4 core: done pulse CORE_DLY cycles after go; inject_done forces a pulse.
   int go_total = 0, core_timer = 0;
   logic [127:0] core_din = '0;
   logic core_en = 1'b1, inject_done = 1'b0;
   always @(negedge clk) begin
      sm4_done = 1'b0;
      if (core_timer > 0) begin
         core_timer--;
         if (core_timer == 0) begin
            sm4_done = 1'b1;
            sm4_dout = cipher(core_din, sm4_key);
         end
      end
      if (inject_done) begin
         sm4_done = 1'b1;
         sm4_dout = '1;
      end
      if (sm4_go === 1'b1) begin
         go_total++;
         if (core_en) begin
            core_din = sm4_din;
            core_timer = CORE_DLY;
         end
      end
   end

   int tx_total = 0;
   logic [127:0] tx_log [1024];
   always @(negedge clk) begin
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         tx_log[tx_total % 1024] = tx_data;
         tx_total++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] gt;
      logic [2:0]  bat;
      int          bpf;
      int          acks;
      int          ntx;
      int          cnt;
   } vec_t;

   task automatic run_session(input vec_t v, input logic [127:0] key);
      int tx0, ack0, kl0, n;
      tx0 = tx_total; ack0 = ack_total; kl0 = kl_total; frame_base = ack_total;
      key_in = key; group_total = v.gt; battery_level = v.bat; start = 1'b1;
      tick();
      for (int i = 0; i < LIMIT && all_done !== 1'b1; i++) tick();
      check("all_done", 128'(all_done), 128'(1));
      check("group_cnt", 128'(group_cnt), 128'(v.cnt));
      check("tx_count", 128'(tx_total - tx0), 128'(v.ntx));
      check("ack_count", 128'(ack_total - ack0), 128'(v.acks));
      check("key_load_count", 128'(kl_total - kl0), 128'((v.gt == 0) ? 0 : 1));
      check("busy_done", 128'(busy), 128'(0));
      n = tx_total - tx0;
      if (n > v.ntx) n = v.ntx;
      for (int i = 0; i < n; i++)
         check("ciphertext", tx_log[(tx0 + i) % 1024], cipher(plain(i / v.bpf, i % v.bpf), key));
      start = 1'b0;
      tick();
      tick();
      check("all_done_clear", 128'(all_done), 128'(0));
      check("cnt_hold", 128'(group_cnt), 128'(v.cnt));
   endtask

   vec_t vecs [6];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int tx0, kl0, go0, bad;
      logic [127:0] d;

      //               gt  bat bpf acks ntx cnt
      vecs[0] = '{32'd4, 3'd2, 2, 1, 4, 4};
      vecs[1] = '{32'd5, 3'd1, 3, 1, 5, 5};
      vecs[2] = '{32'd0, 3'd1, 3, 0, 0, 0};
      vecs[3] = '{32'd3, 3'd5, 1, 2, 3, 3};
      vecs[4] = '{32'd2, 3'd2, 2, 0, 2, 2};
      vecs[5] = '{32'd1, 3'd0, 1, 0, 1, 1};

      tick(); tick(); tick();
      check("rst_tx_valid", 128'(tx_valid), 128'(0));
      check("rst_group_cnt", 128'(group_cnt), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_all_done", 128'(all_done), 128'(0));
      check("rst_err", 128'(err), 128'(0));
      check("rst_strobes", 128'({sm4_go, sm4_key_load, frame_ack}), 128'(0));
      check("rst_sm4_key", sm4_key, 128'(0));
      check("rst_sm4_din", sm4_din, 128'(0));
      check("rst_tx_data", tx_data, 128'(0));
      res = 1'b1;
      tick();

      // Zero-group session: all_done two cycles after start, no key load.
      kl0 = kl_total;
      group_total = '0; key_in = KEY; start = 1'b1;
      tick();
      check("gt0_all_done_c1", 128'(all_done), 128'(0));
      tick();
      check("gt0_all_done_c2", 128'(all_done), 128'(1));
      check("gt0_no_key_load", 128'(kl_total - kl0), 128'(0));
      start = 1'b0;
      tick(); tick();

      // Abort in BLK_WAIT coincident with sm4_done.
      tx0 = tx_total; frame_base = ack_total;
      key_in = KEY; group_total = 32'd4; battery_level = 3'd2; tx_ready = 1'b1; start = 1'b1;
      for (int i = 0; i < LIMIT && (tx_total - tx0) < 1; i++) tick();
      core_en = 1'b0;
      for (int i = 0; i < LIMIT && sm4_go !== 1'b1; i++) tick();
      check("abort_go_seen", 128'(sm4_go), 128'(1));
      tick(); tick();
      abort = 1'b1; inject_done = 1'b1; start = 1'b0;
      tick();
      abort = 1'b0; inject_done = 1'b0;
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_tx_valid", 128'(tx_valid), 128'(0));
      check("abort_group_cnt", 128'(group_cnt), 128'(1));
      tick(); tick(); tick();
      check("abort_tx_valid_later", 128'(tx_valid), 128'(0));
      check("abort_tx_count", 128'(tx_total - tx0), 128'(1));
      core_en = 1'b1;

      for (int v = 0; v < 6; v++) run_session(vecs[v], KEY ^ 128'(v * 32'h0101_0101));

      // Transmitter stall of 50 cycles, then go timing after accept.
      tx0 = tx_total; frame_base = ack_total;
      key_in = KEY; group_total = 32'd2; battery_level = 3'd2; tx_ready = 1'b0; start = 1'b1;
      for (int i = 0; i < LIMIT && tx_valid !== 1'b1; i++) tick();
      check("stall_tx_valid", 128'(tx_valid), 128'(1));
      d = tx_data;
      go0 = go_total;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (tx_valid !== 1'b1 || tx_data !== d) bad++;
      end
      check("stall_stable_cycles_bad", 128'(bad), 128'(0));
      check("stall_no_go", 128'(go_total - go0), 128'(0));
      check("stall_data", d, cipher(plain(0, 0), KEY));
      tx_ready = 1'b1;
      tick();
      check("accept_tx_valid_low", 128'(tx_valid), 128'(0));
      check("accept_go_c1", 128'(sm4_go), 128'(0));
      tick();
      check("accept_go_c2", 128'(sm4_go), 128'(1));
      check("accept_din", sm4_din, plain(0, 1));
      for (int i = 0; i < LIMIT && all_done !== 1'b1; i++) tick();
      check("stall_all_done", 128'(all_done), 128'(1));
      check("stall_group_cnt", 128'(group_cnt), 128'(2));
      check("stall_tx_count", 128'(tx_total - tx0), 128'(2));
      start = 1'b0;
      tick(); tick();

`ifdef SM4_TIMEOUT_EN
      // Watchdog: withheld sm4_done, err after 16 cycles in BLK_WAIT.
      frame_base = ack_total;
      core_en = 1'b0;
      key_in = KEY; group_total = 32'd1; battery_level = 3'd0; start = 1'b1;
      for (int i = 0; i < LIMIT && sm4_go !== 1'b1; i++) tick();
      check("wd_go_seen", 128'(sm4_go), 128'(1));
      for (int i = 0; i < 15; i++) tick();
      check("wd_err_early", 128'(err), 128'(0));
      tick(); tick();
      check("wd_err", 128'(err), 128'(1));
      check("wd_busy", 128'(busy), 128'(1));
      abort = 1'b1; start = 1'b0;
      tick();
      abort = 1'b0;
      check("wd_err_clear", 128'(err), 128'(0));
      check("wd_idle", 128'(busy), 128'(0));
      core_en = 1'b1;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
